retospect_cfg_loader: RTL
=========================

Name: retospect_cfg_loader

Overview:
- Front end to the neurochip configuration bitstream chain (clockbox, then CNB cells 0..N-1).
- Accepts configuration bytes over a valid/ready interface and serialises them LSB-first onto the chain's serial input, gated by config_en.
- Captures the bits falling out of the chain end and returns them as readback bytes, so firmware can read the old configuration while writing the new one.

Parameters:
- CHAIN_LEN, 523: total chain bits (48 clockbox + 25 cells x 19).
- CNT_W, 10: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- wr_data  in  8  config byte, bit 0 shifted first.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  loader accepts wr_data this cycle.
- rd_data  out  8  readback byte, first-emerged bit in bit 0.
- rd_valid  out  1  rd_data valid; held until accepted.
- rd_ready  in  1  consumer accepts rd_data.
- config_en  out  1  chain shift enable (drives every chain element).
- bs_out  out  1  serial data into chain head.
- bs_ret  in  1  serial data from chain tail.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when load completes.

Behaviour:
- Reset (sync, highest priority, any state): state=IDLE. wr_ready, rd_valid, config_en, bs_out, busy, done all 0. rd_data=0, counters and buffers cleared. Reset mid-load abandons the load; chain contents are then undefined.
- States: IDLE, SHIFT, DRAIN, FIN.
- IDLE:
  - start=1 -> SHIFT; bit_cnt=0, in_cnt=0, rb_cnt=0.
  - start is ignored in every other state.
- SHIFT:
  - Input buffer in_buf[7:0] plus in_cnt (bits remaining, 0..8).
  - wr_ready = (state==SHIFT) && in_cnt==0 && bytes still owed. Bytes owed = ceil(CHAIN_LEN/8) = 66 at default.
  - Handshake wr_valid && wr_ready loads in_buf; in_cnt = min(8, CHAIN_LEN - bits already loaded). Unused high bits of the final byte are discarded.
- Shift cycle: condition is SHIFT && in_cnt>0 && !(rb_cnt==8 && rd_valid).
  - config_en and bs_out are registered. On the shift-cycle edge, config_en<=1 and bs_out<=in_buf[0]; in_buf>>=1, in_cnt--, bit_cnt++. Otherwise config_en<=0.
  - The chain shifts on the edge after config_en rises. On that same edge the loader samples bs_ret (the bit leaving the chain) into the readback shift register: rb_sr[rb_cnt]=bs_ret, rb_cnt++.
- Readback:
  - When rb_cnt reaches 8, or the CHAIN_LEN-th returned bit is captured, and rd_valid==0: rd_data<=rb_sr with unfilled high bits 0, rd_valid<=1, rb_cnt<=0.
  - rd_valid drops on rd_valid && rd_ready. It is never dropped otherwise, and rd_data is stable while rd_valid=1.
- Stall rule: if rb_cnt==8 and rd_valid is still pending, no shift occurs; config_en=0 and no chain data is lost.
- Throughput: one bit per cycle when both sides are never stalled.
- Transitions:
  - bit_cnt==CHAIN_LEN after the last issued shift -> DRAIN.
  - DRAIN: wait for the final returned bit capture, the final rd_data transfer, and rd_valid cleared -> FIN.
  - FIN: done=1 for exactly one cycle -> IDLE.
- busy=1 in SHIFT, DRAIN and FIN; 0 in IDLE.
- Exactly CHAIN_LEN config_en cycles and exactly ceil(CHAIN_LEN/8) rd transfers per load.
- wr_valid in IDLE is not accepted (wr_ready=0).

Test Plan:
- Reset then idle: wr_valid=1 without start -> wr_ready=0, config_en=0, rd_valid=0 for 20 cycles.
- CHAIN_LEN=16, bytes 0xA5, 0x3C, rd_ready=1, bs_ret looped to bs_out through a 16-stage model chain preloaded 0xBEEF -> bs_out sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; rd bytes 0xEF then 0xBE; 16 config_en cycles; done pulse; model then holds 0x3CA5.
- CHAIN_LEN=523 full load, 66 bytes 0xFF -> the final byte contributes 3 bits; exactly 523 config_en cycles; final rd_data has bits [7:3]=0; 66 readback transfers.
- Backpressure: rd_ready=0 after the first byte -> config_en stays 0 once 8 more bits are captured; raising rd_ready resumes shifting with no missing or duplicated bits versus the model.
- wr_valid gaps (valid every 11th cycle) -> config_en idles between bytes; chain contents still exact.
- reset asserted mid-SHIFT at bit 7 -> next cycle config_en=0, busy=0; a subsequent start performs a full correct load.

Source files
------------

// File: rtl/retospect_cfg_loader.sv
// Configuration chain loader: serialises config bytes LSB-first into the chain
// head while collecting the bits falling out of the chain tail as readback bytes.
module retospect_cfg_loader #(
    parameter int unsigned CHAIN_LEN = 523,
    parameter int unsigned CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       config_en,
    output logic       bs_out,
    input  logic       bs_ret,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] LenC = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {StIdle, StShift, StDrain, StFin} state_t;

    state_t           state;
    logic [7:0]       in_buf;
    logic [3:0]       in_cnt;   // bits still to shift out of in_buf
    logic [CNT_W-1:0] ld_cnt;   // bits accepted from wr_data so far
    logic [CNT_W-1:0] bit_cnt;  // shifts issued
    logic [CNT_W-1:0] ret_cnt;  // returned bits captured
    logic [7:0]       rb_sr;
    logic [3:0]       rb_cnt;

    logic [CNT_W-1:0] remain;
    logic [3:0]       load_n;
    logic [3:0]       rb_fill;
    logic             wr_fire;
    logic             stall;
    logic             shift_go;
    logic             all_back;
    logic             xfer;
    logic [7:0]       rb_sr_d;
    logic [3:0]       rb_cnt_d;

    assign wr_ready = (state == StShift) && (in_cnt == 4'd0) && (ld_cnt != LenC);
    assign wr_fire  = wr_valid && wr_ready;
    assign remain   = LenC - ld_cnt;
    // A bit already on the wire (config_en high) will land in rb_sr next edge,
    // so it counts towards the readback occupancy when deciding to stall.
    assign rb_fill  = rb_cnt + {3'b000, config_en};
    assign stall    = rd_valid && (rb_fill >= 4'd8);
    assign shift_go = (state == StShift) && (in_cnt != 4'd0) && !stall;
    assign all_back = (ret_cnt == LenC);
    assign xfer     = !rd_valid && ((rb_cnt == 4'd8) || (all_back && rb_cnt != 4'd0));

    // Final byte may carry fewer than 8 useful bits.
    always_comb begin
        if (remain >= CNT_W'(8)) begin
            load_n = 4'd8;
        end else begin
            load_n = remain[3:0];
        end
    end

    // Readback register next state: empty on transfer, then absorb the returning bit.
    always_comb begin
        rb_sr_d  = rb_sr;
        rb_cnt_d = rb_cnt;
        if (xfer) begin
            rb_sr_d  = 8'h00;
            rb_cnt_d = 4'd0;
        end
        if (config_en) begin
            rb_sr_d[rb_cnt_d[2:0]] = bs_ret;
            rb_cnt_d               = rb_cnt_d + 4'd1;
        end
    end

    // Control FSM, serialiser and readback state with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            in_buf    <= 8'h00;
            in_cnt    <= 4'd0;
            ld_cnt    <= '0;
            bit_cnt   <= '0;
            ret_cnt   <= '0;
            rb_sr     <= 8'h00;
            rb_cnt    <= 4'd0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            config_en <= 1'b0;
            bs_out    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            config_en <= 1'b0;
            done      <= 1'b0;
            rb_sr     <= rb_sr_d;
            rb_cnt    <= rb_cnt_d;
            if (config_en) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            if (xfer) begin
                rd_data  <= rb_sr;
                rd_valid <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StShift;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        in_cnt  <= 4'd0;
                        ld_cnt  <= '0;
                        ret_cnt <= '0;
                        rb_cnt  <= 4'd0;
                        rb_sr   <= 8'h00;
                    end
                end
                StShift: begin
                    if (wr_fire) begin
                        in_buf <= wr_data;
                        in_cnt <= load_n;
                        ld_cnt <= ld_cnt + {{(CNT_W-4){1'b0}}, load_n};
                    end
                    if (shift_go) begin
                        config_en <= 1'b1;
                        bs_out    <= in_buf[0];
                        in_buf    <= in_buf >> 1;
                        in_cnt    <= in_cnt - 4'd1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    if (bit_cnt == LenC) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (all_back && !config_en && rb_cnt == 4'd0 && !rd_valid) begin
                        state <= StFin;
                        done  <= 1'b1;
                    end
                end
                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
